// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Full subtractor cell: returns {borrow_next, difference_bit}.
    function automatic logic [1:0] full_sub(input logic ai, input logic bi, input logic bri);
        logic d_bit;
        logic br_nxt;
        d_bit  = ai ^ bi ^ bri;
        br_nxt = (~ai & bi) | (~(ai ^ bi) & bri);
        return {br_nxt, d_bit};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       bit_s;
    logic [WIDTH-1:0] res_full_s;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Next-state, datapath shift and completion capture.
    always_comb begin
        state_d    = state_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        res_d      = res_q;
        br_d       = br_q;
        cnt_d      = cnt_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d      = ovf_q;
`endif
        bit_s      = full_sub(a_sr_q[0], b_sr_q[0], br_q);
        // Incoming bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
        res_full_s = {bit_s[0], res_q};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                br_d   = bit_s[1];
                res_d  = res_full_s[WIDTH-1:1];
                if (cnt_q == CNT_LAST) begin
                    diff_d   = res_full_s;
                    borrow_d = bit_s[1];
`ifdef SERIAL_SUB_OVF_EN
                    // On the last bit the shift-register LSBs are the operand MSBs.
                    ovf_d    = (a_sr_q[0] != b_sr_q[0]) && (bit_s[0] != a_sr_q[0]);
`endif
                    state_d  = ST_DONE;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Overflow flag, updated together with diff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit instance with directed vectors and a
// 2-bit instance swept over all operand pairs. Checks ovf when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] d;
        logic       br;
        logic       ov;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start, start2;
    logic [7:0] a, b, diff;
    logic [1:0] a2, b2, diff2;
    logic       busy, done, borrow_out;
    logic       busy2, done2, borrow2;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf, ovf2;
`endif

    exp_t       q[$];
    exp_t       q2[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] last_diff = 8'h00;

    serial_subtractor #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_subtractor #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .diff(diff2), .borrow_out(borrow2)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("borrow_out", 32'(borrow_out), 32'(e.br));
                check("done_cycle", cyc, e.cyc);
                check("busy_at_done", 32'(busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ov));
`endif
            end
        end
    end

    // Monitor for the 2-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done2: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                e = q2.pop_front();
                check("diff2", 32'(diff2), 32'(e.d));
                check("borrow2", 32'(borrow2), 32'(e.br));
                check("done_cycle2", cyc, e.cyc);
`ifdef SERIAL_SUB_OVF_EN
                check("ovf2", 32'(ovf2), 32'(e.ov));
`endif
            end
        end
    end

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb, input logic eo);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        q.push_back('{ed, eb, eo, cyc + 8});
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check("busy_in_shift", 32'(busy), 32'd1);
            check("no_done_in_shift", 32'(done), 32'd0);
            check("diff_stable", 32'(diff), 32'(last_diff));
        end
        @(negedge clk);
        last_diff = ed;
    endtask

    initial begin
        int d0;
        int seen;
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
        start2 = 1'b0; a2 = 2'd0; b2 = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Start pulse during SHIFT must be ignored.
        @(negedge clk);
        a = 8'h05; b = 8'h03; start = 1'b1;
        @(posedge clk);
        #1;
        q.push_back('{8'h02, 1'b0, 1'b0, cyc + 8});
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'hAA; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 20 && !done; n++) @(negedge clk);
        check("done_seen_05_03", 32'(done), 32'd1);
        d0 = cyc;

        // Start held high: back-to-back operations every 10 cycles.
        a = 8'h30; b = 8'h10; start = 1'b1;
        for (int k = 1; k <= 3; k++) q.push_back('{8'h20, 1'b0, 1'b0, d0 + 10 * k});
        seen = 0;
        for (int n = 0; n < 40 && seen < 3; n++) begin
            @(negedge clk);
            if (done) seen++;
        end
        start = 1'b0;
        check("held_start_ops", seen, 32'd3);
        repeat (15) @(negedge clk);
        last_diff = 8'h20;

        // Reset in the 4th SHIFT cycle aborts the operation.
        @(negedge clk);
        a = 8'h80; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        last_diff = 8'h00;
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

        // 2-bit instance: every operand pair.
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                logic [1:0] ed2;
                @(negedge clk);
                a2 = 2'(ai); b2 = 2'(bi); start2 = 1'b1;
                ed2 = 2'(ai - bi);
                @(posedge clk);
                #1;
                q2.push_back('{{6'd0, ed2}, (ai < bi),
                              (a2[1] != b2[1]) && (ed2[1] != a2[1]), cyc + 2});
                @(negedge clk);
                start2 = 1'b0;
                repeat (3) @(negedge clk);
            end
        end

        repeat (4) @(negedge clk);
        check("q_drained", q.size(), 32'd0);
        check("q2_drained", q2.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running expected finish");
        $fatal(1);
    end

endmodule
